// File: rtl/eth_hdr_strip_realign.sv
// RX-path Ethernet header stripper: parses MAC/VLAN/ethertype from beat 0,
// publishes the header on a one-entry channel and streams the payload
// realigned so that the first payload byte lands in the MSBs of dst_data.
module eth_hdr_strip_realign #(
    parameter int DATA_W   = 256,
    parameter int PAD_W    = $clog2(DATA_W/8),
    parameter int MTU_W    = 16,
    parameter int MAX_VLAN = 2,
    parameter int TS_W     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_val,
    input  logic [DATA_W-1:0]              src_data,
    input  logic [MTU_W-1:0]               src_frame_size,
    input  logic                           src_last,
    input  logic [PAD_W-1:0]               src_padbytes,
    output logic                           src_rdy,
    output logic                           hdr_val,
    input  logic                           hdr_rdy,
    output logic [47:0]                    hdr_dst_mac,
    output logic [47:0]                    hdr_src_mac,
    output logic [15:0]                    hdr_eth_type,
    output logic [$clog2(MAX_VLAN+1)-1:0]  hdr_vlan_cnt,
    output logic [16*MAX_VLAN-1:0]         hdr_vlan_tci,
    output logic [MTU_W-1:0]               hdr_data_size,
    output logic [TS_W-1:0]                hdr_timestamp,
    output logic                           dst_val,
    input  logic                           dst_rdy,
    output logic [DATA_W-1:0]              dst_data,
    output logic                           dst_last,
    output logic [PAD_W-1:0]               dst_padbytes,
    output logic                           runt_drop
);

    localparam int B    = DATA_W/8;
    localparam int HW   = PAD_W + 1;              // wide enough to hold B and H
    localparam int VC_W = $clog2(MAX_VLAN+1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic                drain_q, drain_d;        // swallowing the rest of a runt
    logic [DATA_W-1:0]   tail_q, tail_d;          // B-H carried bytes, MSB-aligned
    logic [HW-1:0]       h_q, h_d;                // header length of current frame
    logic [PAD_W-1:0]    pad_q, pad_d;            // padbytes of the last beat seen
    logic                runt_q, runt_d;
    logic                hdr_load;
    logic [TS_W-1:0]     ts_q;

    logic [VC_W-1:0]     p_cnt;
    logic [HW-1:0]       p_h;
    logic [15:0]         p_type;
    logic [15:0]         tpid;
    logic [16*MAX_VLAN-1:0] p_tci;
    logic                stop;
    logic [HW-1:0]       v_bytes, b0_valid;
    logic                runt;

    function automatic logic [15:0] get16(input logic [DATA_W-1:0] d, input int idx);
        return d[DATA_W-1-8*idx -: 16];
    endfunction

    // Beat-0 parse: count consecutive recognised tags, then pick the ethertype after them
    always_comb begin
        p_cnt = '0;
        p_tci = '0;
        stop  = 1'b0;
        tpid  = '0;
        for (int k = 0; k < MAX_VLAN; k++) begin
            tpid = get16(src_data, 12 + 4*k);
            if (!stop && (tpid == 16'h8100 || tpid == 16'h88A8)) begin
                p_cnt = p_cnt + VC_W'(1);
                p_tci[16*(MAX_VLAN-k)-1 -: 16] = get16(src_data, 14 + 4*k);
            end else begin
                stop = 1'b1;
            end
        end
        p_type   = get16(src_data, 12 + 4*int'(p_cnt));
        p_h      = HW'(14 + 4*int'(p_cnt));
        v_bytes  = HW'(B) - {1'b0, src_padbytes};
        b0_valid = src_last ? v_bytes : HW'(B);
        runt     = (src_frame_size < MTU_W'(p_h)) || (b0_valid < p_h);
    end

    // Data-path FSM: next state, tail capture and combinational payload output
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        tail_d       = tail_q;
        h_d          = h_q;
        pad_d        = pad_q;
        hdr_load     = 1'b0;
        runt_d       = 1'b0;
        src_rdy      = 1'b0;
        dst_val      = 1'b0;
        dst_data     = '0;
        dst_last     = 1'b0;
        dst_padbytes = '0;
        case (state_q)
            S_IDLE: begin
                if (drain_q) begin
                    src_rdy = !rst;
                    if (src_val && src_last) drain_d = 1'b0;
                end else begin
                    // a pending header blocks the next frame's beat 0
                    src_rdy = !hdr_val && !rst;
                    if (src_val && !hdr_val) begin
                        if (runt) begin
                            runt_d  = 1'b1;
                            drain_d = !src_last;
                        end else begin
                            hdr_load = 1'b1;
                            tail_d   = src_data << {p_h, 3'b000};
                            h_d      = p_h;
                            pad_d    = src_padbytes;
                            if (!src_last)
                                state_d = S_STREAM;
                            else if (b0_valid != p_h)
                                state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_STREAM: begin
                src_rdy  = dst_rdy;
                dst_val  = src_val;
                dst_data = tail_q | (src_data >> {HW'(B) - h_q, 3'b000});
                // a short last beat fits entirely behind the tail
                if (src_last && v_bytes <= h_q) begin
                    dst_last     = 1'b1;
                    dst_padbytes = PAD_W'(h_q + {1'b0, src_padbytes} - HW'(B));
                end
                if (src_val && dst_rdy) begin
                    tail_d = src_data << {h_q, 3'b000};
                    pad_d  = src_padbytes;
                    if (src_last) state_d = (v_bytes <= h_q) ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                dst_val      = 1'b1;
                dst_data     = tail_q;
                dst_last     = 1'b1;
                dst_padbytes = PAD_W'(h_q + {1'b0, pad_q});
                if (dst_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, timestamp counter, runt pulse and the one-entry header register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            drain_q       <= 1'b0;
            tail_q        <= '0;
            h_q           <= '0;
            pad_q         <= '0;
            runt_q        <= 1'b0;
            ts_q          <= '0;
            hdr_val       <= 1'b0;
            hdr_dst_mac   <= '0;
            hdr_src_mac   <= '0;
            hdr_eth_type  <= '0;
            hdr_vlan_cnt  <= '0;
            hdr_vlan_tci  <= '0;
            hdr_data_size <= '0;
            hdr_timestamp <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            tail_q  <= tail_d;
            h_q     <= h_d;
            pad_q   <= pad_d;
            runt_q  <= runt_d;
            ts_q    <= ts_q + TS_W'(1);
            if (hdr_load) begin
                hdr_val       <= 1'b1;
                hdr_dst_mac   <= src_data[DATA_W-1 -: 48];
                hdr_src_mac   <= src_data[DATA_W-49 -: 48];
                hdr_eth_type  <= p_type;
                hdr_vlan_cnt  <= p_cnt;
                hdr_vlan_tci  <= p_tci;
                hdr_data_size <= src_frame_size - MTU_W'(p_h);
                hdr_timestamp <= ts_q;
            end else if (hdr_rdy) begin
                hdr_val <= 1'b0;
            end
        end
    end

    assign runt_drop = runt_q;

endmodule
